// File: rtl/cdb_arbiter.sv
// cdb_arbiter: Common Data Bus arbiter.
// Each functional-unit source has a 1-entry result slot. One full slot is
// broadcast per cycle on the CDB. Speculative results are dropped when a
// branch resolves as mispredicted, and are promoted to non-speculative when
// the branch resolves as correctly predicted.
// Optional build macro: CDB_FIXED_PRIO_EN selects fixed priority (lowest
// eligible index wins) instead of round-robin arbitration.
module cdb_arbiter #(
    parameter int NUM_SRC           = 4,
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_TAG            = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_SRC-1:0]                   i_fu_valid,
    output logic [NUM_SRC-1:0]                   o_fu_ready,
    input  logic [NUM_SRC*BW_TAG-1:0]            i_fu_tag_flatten,
    input  logic [NUM_SRC*BW_PROCESSOR_DATA-1:0] i_fu_data_flatten,
    input  logic [NUM_SRC-1:0]                   i_fu_speculation,
    input  logic                                 i_branch_valid,
    input  logic                                 i_branch_correct_prediction,
    output logic                                 o_cdb_valid,
    output logic [BW_TAG-1:0]                    o_cdb_tag,
    output logic signed [BW_PROCESSOR_DATA-1:0]  o_cdb_wdata,
    output logic [$clog2(NUM_SRC)-1:0]           o_cdb_src
);

    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]           slot_full;
    logic [NUM_SRC-1:0]           slot_spec;
    logic [BW_TAG-1:0]            slot_tag  [NUM_SRC];
    logic [BW_PROCESSOR_DATA-1:0] slot_data [NUM_SRC];

    logic                         flush;
    logic                         commit;
    logic [NUM_SRC-1:0]           eligible;
    logic [NUM_SRC-1:0]           granted;
    logic [NUM_SRC-1:0]           accept;
    logic                         grant_valid;
    logic [SRC_W-1:0]             grant_idx;
    logic [SRC_W-1:0]             scan_base;

    assign flush  = i_branch_valid & ~i_branch_correct_prediction;
    assign commit = i_branch_valid &  i_branch_correct_prediction;

    // A speculative slot is invisible to arbitration in the flush cycle itself.
    assign eligible   = slot_full & ~({NUM_SRC{flush}} & slot_spec);
    assign o_fu_ready = ~slot_full | granted;
    assign accept     = i_fu_valid & o_fu_ready;

`ifdef CDB_FIXED_PRIO_EN
    // Fixed priority: scanning always starts at source 0.
    assign scan_base = '0;
`else
    logic [SRC_W-1:0] rr_ptr;

    // Round-robin pointer: next scan starts just past the last granted source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            if (grant_idx == SRC_W'(NUM_SRC - 1)) rr_ptr <= '0;
            else                                  rr_ptr <= grant_idx + SRC_W'(1);
        end
    end

    assign scan_base = rr_ptr;
`endif

    // Grant: first eligible slot scanning scan_base, scan_base+1, ... (mod NUM_SRC).
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        granted     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(scan_base) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!grant_valid && eligible[idx]) begin
                grant_valid  = 1'b1;
                grant_idx    = SRC_W'(idx);
                granted[idx] = 1'b1;
            end
        end
    end

    // Broadcast is combinational from the granted slot; zeros when idle.
    always_comb begin
        o_cdb_valid = grant_valid;
        o_cdb_tag   = '0;
        o_cdb_wdata = '0;
        o_cdb_src   = '0;
        if (grant_valid) begin
            o_cdb_tag   = slot_tag[grant_idx];
            o_cdb_wdata = slot_data[grant_idx];
            o_cdb_src   = grant_idx;
        end
    end

    // Slot occupancy and speculation bits: accept, grant, flush and commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full <= '0;
            slot_spec <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept[i]) begin
                    // Tag 0 or a result flushed on arrival completes the
                    // handshake but leaves the slot empty.
                    slot_full[i] <= (i_fu_tag_flatten[i*BW_TAG +: BW_TAG] != '0) &&
                                    !(flush && i_fu_speculation[i]);
                    slot_spec[i] <= i_fu_speculation[i] & ~commit;
                end else begin
                    if (granted[i] || (flush && slot_spec[i])) slot_full[i] <= 1'b0;
                    if (commit) slot_spec[i] <= 1'b0;
                end
            end
        end
    end

    // Slot payload: loaded on accept only.
    // NOTE: tag/data are not reset; they are only observed while slot_full
    // is set, and slot_full itself is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                slot_tag[i]  <= i_fu_tag_flatten[i*BW_TAG +: BW_TAG];
                slot_data[i] <= i_fu_data_flatten[i*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
            end
        end
    end

endmodule
